pwm_generator: RTL and testbench

- Free-running N-bit PWM generator driving one digital output (LED dimming, motor/servo drive, DAC-by-filtering).
- An N-bit counter sweeps 0..2^N-1. The output is high while the counter is below `compare`.
- Sits directly behind a control register or bus-decoded value. Feeds a pad or a downstream filter.

---
 rtl/pwm_pkg.sv | 11 +
 rtl/pwm_counter.sv | 32 +++
 rtl/pwm_generator.sv | 49 ++++
 tb/tb_pwm_generator.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the PWM generator and its integrators.
package pwm_pkg;

    localparam int unsigned PWM_CTR_LEN_DEFAULT = 8;

    // PWM period in clocks for a counter of the given width (up to 32 bits).
    function automatic logic [32:0] pwm_period(input int unsigned len);
        return 33'd1 << len;
    endfunction

endpackage

// File: rtl/pwm_counter.sv
// Free-running CTR_LEN-bit wrap counter with a flag marking the zero count.
module pwm_counter
    import pwm_pkg::*;
#(
    parameter int unsigned CTR_LEN = PWM_CTR_LEN_DEFAULT
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    output logic [CTR_LEN-1:0] ctr_o,
    output logic               wrap_o
);

    logic [CTR_LEN-1:0] ctr_q;
    logic [CTR_LEN-1:0] ctr_d;

    // Natural modulo-2^CTR_LEN wrap; no enable or stall by design.
    always_comb begin
        ctr_d = ctr_q + CTR_LEN'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctr_q <= '0;
        end else begin
            ctr_q <= ctr_d;
        end
    end

    assign ctr_o  = ctr_q;
    assign wrap_o = (ctr_q == '0);

endmodule

// File: rtl/pwm_generator.sv
// Free-running PWM: output high while the counter is below compare, one-clock registered lag.
module pwm_generator
    import pwm_pkg::*;
#(
    parameter int unsigned CTR_LEN = PWM_CTR_LEN_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CTR_LEN-1:0] compare,
    output logic               pwm,
    output logic               period_start
);

    logic [CTR_LEN-1:0] ctr;
    logic               wrap;
    logic               pwm_d;
    logic               pwm_q;
    logic               period_start_d;
    logic               period_start_q;

    pwm_counter #(
        .CTR_LEN (CTR_LEN)
    ) u_counter (
        .clk_i  (clk),
        .rst_ni (rst),
        .ctr_o  (ctr),
        .wrap_o (wrap)
    );

    // Both outputs are decided from the pre-increment count, so they trail ctr by one clock.
    always_comb begin
        pwm_d          = (compare > ctr);
        period_start_d = wrap;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_q          <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            pwm_q          <= pwm_d;
            period_start_q <= period_start_d;
        end
    end

    assign pwm          = pwm_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_generator.sv
// Directed bench for pwm_generator at CTR_LEN=8 and a second instance at CTR_LEN=4.
module tb_pwm_generator;
    import pwm_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] compare;
    logic       pwm;
    logic       period_start;
    logic [3:0] compare4;
    logic       pwm4;
    logic       period_start4;

    int pass_cnt;
    int total_cnt;

    pwm_generator #(.CTR_LEN(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .compare      (compare),
        .pwm          (pwm),
        .period_start (period_start)
    );

    pwm_generator #(.CTR_LEN(4)) dut4 (
        .clk          (clk),
        .rst          (rst),
        .compare      (compare4),
        .pwm          (pwm4),
        .period_start (period_start4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sync8(output bit found);
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (period_start === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic sync4(output bit found);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (period_start4 === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        compare  = 8'd128;
        compare4 = 4'd5;
        for (int i = 0; i < 2; i++) begin
            tick();
            total_cnt++;
            if (pwm !== 1'b0) $display("FAIL reset_pwm cycle %0d: got %b want 0", i, pwm);
            else pass_cnt++;
            total_cnt++;
            if (period_start !== 1'b0) $display("FAIL reset_ps cycle %0d: got %b want 0", i, period_start);
            else pass_cnt++;
        end
        rst = 1'b1;
        tick();
        total_cnt++;
        if (period_start !== 1'b1) $display("FAIL first_ps: got %b want 1", period_start);
        else pass_cnt++;
        total_cnt++;
        if (pwm !== 1'b1) $display("FAIL first_pwm: got %b want 1", pwm);
        else pass_cnt++;
    endtask

    task automatic test_duty(input logic [7:0] cmp, input string name);
        bit found;
        int highs;
        int bad;
        int len;
        compare = cmp;
        sync8(found);
        total_cnt++;
        if (!found) begin
            $display("FAIL %s_sync: got no period_start want one within 300 cycles", name);
            return;
        end
        pass_cnt++;
        highs = 0;
        bad   = 0;
        len   = 0;
        for (int i = 0; i < 256; i++) begin
            if (pwm === 1'b1) highs++;
            if (pwm !== ((i < int'(cmp)) ? 1'b1 : 1'b0)) bad++;
            if (i > 0 && period_start === 1'b1 && len == 0) len = i;
            tick();
        end
        if (len == 0 && period_start === 1'b1) len = 256;
        total_cnt++;
        if (highs != int'(cmp)) $display("FAIL %s_highs: got %0d want %0d", name, highs, cmp);
        else pass_cnt++;
        total_cnt++;
        if (bad != 0) $display("FAIL %s_pattern: got %0d misplaced cycles want 0", name, bad);
        else pass_cnt++;
        total_cnt++;
        if (len != 256) $display("FAIL %s_period: got %0d want 256", name, len);
        else pass_cnt++;
    endtask

    task automatic test_zero();
        int highs;
        compare = 8'd0;
        tick();
        highs = 0;
        for (int i = 0; i < 512; i++) begin
            tick();
            if (pwm !== 1'b0) highs++;
        end
        total_cnt++;
        if (highs != 0) $display("FAIL zero_duty: got %0d high cycles want 0", highs);
        else pass_cnt++;
    endtask

    task automatic test_full();
        bit found;
        int lows;
        int low_idx;
        compare = 8'd255;
        sync8(found);
        total_cnt++;
        if (!found) begin
            $display("FAIL full_sync: got no period_start want one within 300 cycles");
            return;
        end
        pass_cnt++;
        lows    = 0;
        low_idx = -1;
        for (int i = 0; i < 256; i++) begin
            if (pwm !== 1'b1) begin
                lows++;
                low_idx = i;
            end
            tick();
        end
        total_cnt++;
        if (lows != 1) $display("FAIL full_lows: got %0d want 1", lows);
        else pass_cnt++;
        total_cnt++;
        if (low_idx != 255) $display("FAIL full_low_pos: got %0d want 255", low_idx);
        else pass_cnt++;
        total_cnt++;
        if (period_start !== 1'b1) $display("FAIL full_next_ps: got %b want 1", period_start);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        bit found;
        int highs;
        int len;
        compare = 8'd128;
        sync8(found);
        total_cnt++;
        if (!found) begin
            $display("FAIL async_sync: got no period_start want one within 300 cycles");
            return;
        end
        pass_cnt++;
        for (int i = 0; i < 10; i++) tick();
        total_cnt++;
        if (pwm !== 1'b1) $display("FAIL async_pre_pwm: got %b want 1", pwm);
        else pass_cnt++;
        #2;
        rst = 1'b0;
        #1;
        total_cnt++;
        if (pwm !== 1'b0) $display("FAIL async_pwm_drop: got %b want 0", pwm);
        else pass_cnt++;
        total_cnt++;
        if (period_start !== 1'b0) $display("FAIL async_ps_drop: got %b want 0", period_start);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        tick();
        total_cnt++;
        if (period_start !== 1'b1) $display("FAIL async_restart_ps: got %b want 1", period_start);
        else pass_cnt++;
        highs = 0;
        len   = 0;
        for (int i = 0; i < 300; i++) begin
            if (pwm === 1'b1) highs++;
            tick();
            if (period_start === 1'b1) begin
                len = i + 1;
                break;
            end
        end
        total_cnt++;
        if (len != 256) $display("FAIL async_first_period: got %0d want 256", len);
        else pass_cnt++;
        total_cnt++;
        if (highs != 128) $display("FAIL async_first_highs: got %0d want 128", highs);
        else pass_cnt++;
    endtask

    task automatic test_width4();
        bit found;
        int highs;
        int bad;
        sync4(found);
        total_cnt++;
        if (!found) begin
            $display("FAIL w4_sync: got no period_start want one within 40 cycles");
            return;
        end
        pass_cnt++;
        highs = 0;
        bad   = 0;
        for (int i = 0; i < 16; i++) begin
            if (pwm4 === 1'b1) highs++;
            if (pwm4 !== ((i < 5) ? 1'b1 : 1'b0)) bad++;
            if (i > 0 && period_start4 !== 1'b0) bad++;
            tick();
        end
        total_cnt++;
        if (highs != 5) $display("FAIL w4_highs: got %0d want 5", highs);
        else pass_cnt++;
        total_cnt++;
        if (bad != 0) $display("FAIL w4_pattern: got %0d misplaced cycles want 0", bad);
        else pass_cnt++;
        total_cnt++;
        if (period_start4 !== 1'b1) $display("FAIL w4_period: got %b at cycle 16 want 1", period_start4);
        else pass_cnt++;
        total_cnt++;
        if (pwm_period(4) !== 33'd16) $display("FAIL pkg_period: got %0d want 16", pwm_period(4));
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst       = 1'b0;
        compare   = 8'd0;
        compare4  = 4'd5;
        test_reset();
        test_duty(8'd128, "half");
        test_duty(8'd30, "duty30");
        test_zero();
        test_full();
        test_async_reset();
        test_width4();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
